unidade_execucao: RTL and testbench
===================================

# unidade_execucao

Multi-cycle fetch/decode/execute/write-back sequencer for the Lapido processor. It sits directly upstream of the register bank: it fetches 32-bit instructions over a req/ack handshake, drives the bank's read addresses, samples the bank's A/B outputs, computes the result in an internal ALU, and drives the bank's write enable, write address and write data (E).

## Interface

**Parameters**
- `bits_palavra`, 32: data word width; must match the register bank.
- `end_registros`, 4: register address width.
- `largura_pc`, 16: program counter width.

**Ports**
- `clock`, input, 1: single clock. All state updates on posedge.
- `reset`, input, 1: asynchronous, active-high.
- `instr_req`, output, 1: instruction request.
- `instr_ack`, input, 1: instruction valid; sampled only while `instr_req`=1.
- `instrucao`, input, 32: instruction word; captured on the ack cycle.
- `pc`, output, `largura_pc`: address of the instruction being fetched or executed.
- `end_a`, output, `end_registros`: to bank IN_OUT_A; read address A, or write address.
- `end_b`, output, `end_registros`: to bank OUT_B; read address B.
- `habilita`, output, 1: to bank Habilita; write enable.
- `dado_escrita`, output, `bits_palavra`: to bank E; write data.
- `dado_a`, input, `bits_palavra`: from bank A.
- `dado_b`, input, `bits_palavra`: from bank B.
- `parado`, output, 1: HALT executed.
- `ilegal`, output, 1: sticky flag; an illegal opcode was seen.

## Operation

**Instruction format**
- [31:26] opcode, [25:22] rd, [21:18] rs, [17:14] rt, [13:0] imm14.
- `imm` = imm14 sign-extended to `bits_palavra`.

**Opcodes**
- 0x00 NOP.
- 0x01 ADD: rd = rs + rt.
- 0x02 SUB: rd = rs - rt.
- 0x03 AND.
- 0x04 OR.
- 0x05 ADDI: rd = rs + imm.
- 0x06 LI: rd = imm.
- 0x3F HALT.
- Any other opcode: sets `ilegal`=1 and executes as NOP.

**Arithmetic**
- All results are modulo 2^`bits_palavra`. There is no carry or overflow output.
- r0 is an ordinary register; writes to r0 are performed.

**States**
- INICIO: entered on reset. Always moves to BUSCA on the next edge.
- BUSCA: `instr_req`=1. On an edge with `instr_ack`=1, latch `instrucao` into IR and go to DECODIFICA; otherwise stay.
- DECODIFICA: `end_a`=rs, `end_b`=rt, `habilita`=0.
  - NOP or illegal: pc+1, go to BUSCA.
  - HALT: go to PARADO; pc is not incremented.
  - Any other opcode: go to EXECUTA.
- EXECUTA: sample `dado_a`/`dado_b` and register the ALU result into `dado_escrita`. Go to ESCRITA.
- ESCRITA: `habilita`=1, `end_a`=rd, `dado_escrita` stable. pc+1, go to BUSCA.
- PARADO: `parado`=1, all outputs held. Exit only via reset.

**Output rules**
- `habilita`, `instr_req`, `end_a` and `end_b` are registered, so they are glitch-free for the bank's negedge sampling.
- `ilegal` clears only on reset.

## Timing

**Reset values**
- `instr_req`=0, `habilita`=0, `end_a`=0, `end_b`=0, `dado_escrita`=0, `pc`=0, `parado`=0, `ilegal`=0, state=INICIO.
- Reset asserted at any time (including mid-ESCRITA or mid-BUSCA) forces these values immediately, without waiting for a clock edge. `habilita` must drop asynchronously.

**Fetch handshake**
- `instr_req` rises on the first edge after reset release, i.e. the INICIO→BUSCA edge.
- An ack accepted at edge N drops `instr_req` at edge N.
- `instr_ack` while `instr_req`=0 is ignored.

**Bank read timing**
- Addresses driven at posedge N are read by the bank at negedge N+½.
- EXECUTA samples `dado_a`/`dado_b` at posedge N+1.

**Bank write timing**
- `habilita`/`end_a`/`dado_escrita` are valid from the posedge entering ESCRITA through the following posedge.
- The bank writes at the intervening negedge.

**Latency (zero-wait ack)**
- ALU/LI instruction: 4 cycles (BUSCA, DECODIFICA, EXECUTA, ESCRITA).
- NOP or illegal: 2 cycles.
- HALT: 2 cycles to PARADO.
- Each cycle of ack delay adds one cycle.

**Other boundary rules**
- pc wraps from 2^`largura_pc`-1 to 0.
- Back-to-back dependent instructions need no forwarding: each write completes before the next DECODIFICA.

## Test plan

- **Reset:** reset mid-ESCRITA with `habilita`=1 → `habilita`=0 immediately, before the next edge; all outputs at reset values; `instr_req`=1 one edge after release.
- **LI then ADD:** LI r1,5; LI r2,7; ADD r3,r1,r2 (bank model attached) → r3=12; `pc`=3; each instruction takes 4 cycles with zero-wait ack.
- **Sign extension and wrap:** LI r1,-1 → 0xFFFFFFFF; ADDI r2,r1,1 → 0x00000000; SUB r3,r2,r1 → 0x00000001.
- **Illegal and NOP:** opcode 0x10 → `ilegal`=1, no `habilita` pulse, `pc`+1 after 2 cycles; a following NOP leaves `ilegal`=1.
- **Ack delay:** `instr_ack` held low 3 cycles → `instr_req` stays 1, `pc` stable, IR unchanged; ack on the 4th cycle → DECODIFICA on the next cycle.
- **HALT:** HALT at pc=4 → `parado`=1 after 2 cycles, `pc`=4, `instr_req`=0 permanently; further acks ignored until reset.

Source files
------------

// File: rtl/unidade_execucao.sv
// Lapido multi-cycle sequencer: fetch, decode, execute, write-back.
// Drives the register bank ports; the ALU result is registered before write.
module unidade_execucao #(
  parameter int bits_palavra  = 32,
  parameter int end_registros = 4,
  parameter int largura_pc    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     instr_req,
  input  logic                     instr_ack,
  input  logic [31:0]              instrucao,
  output logic [largura_pc-1:0]    pc,
  output logic [end_registros-1:0] end_a,
  output logic [end_registros-1:0] end_b,
  output logic                     habilita,
  output logic [bits_palavra-1:0]  dado_escrita,
  input  logic [bits_palavra-1:0]  dado_a,
  input  logic [bits_palavra-1:0]  dado_b,
  output logic                     parado,
  output logic                     ilegal
);

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_LI   = 6'h06;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    INICIO,
    BUSCA,
    DECODIFICA,
    EXECUTA,
    ESCRITA,
    PARADO
  } estado_t;

  typedef enum logic [1:0] {
    C_NOP,
    C_ILEGAL,
    C_HALT,
    C_EXEC
  } classe_t;

  estado_t                  estado;
  classe_t                  classe;
  logic [31:0]              ir;
  logic [5:0]               op;
  logic [end_registros-1:0] rd;
  logic [end_registros-1:0] rs_in;
  logic [end_registros-1:0] rt_in;
  logic [bits_palavra-1:0]  imm;
  logic [bits_palavra-1:0]  resultado;
  logic [largura_pc-1:0]    pc_inc;

  assign op     = ir[31:26];
  assign rd     = end_registros'(ir[25:22]);
  assign rs_in  = end_registros'(instrucao[21:18]);
  assign rt_in  = end_registros'(instrucao[17:14]);
  assign imm    = {{(bits_palavra-14){ir[13]}}, ir[13:0]};
  assign pc_inc = pc + largura_pc'(1);

  always_comb begin
    classe = C_ILEGAL;
    unique case (1'b1)
      (op == OP_NOP):
        classe = C_NOP;
      (op == OP_HALT):
        classe = C_HALT;
      (op >= OP_ADD && op <= OP_LI):
        classe = C_EXEC;
      default:
        classe = C_ILEGAL;
    endcase
  end

  always_comb begin
    resultado = '0;
    case (op)
      OP_ADD:  resultado = dado_a + dado_b;
      OP_SUB:  resultado = dado_a - dado_b;
      OP_AND:  resultado = dado_a & dado_b;
      OP_OR:   resultado = dado_a | dado_b;
      OP_ADDI: resultado = dado_a + imm;
      OP_LI:   resultado = imm;
      default: resultado = '0;
    endcase
  end

  // Read addresses come straight from the fetched word so the bank
  // samples them on the negedge inside DECODIFICA.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= INICIO;
      ir           <= '0;
      pc           <= '0;
      instr_req    <= 1'b0;
      end_a        <= '0;
      end_b        <= '0;
      habilita     <= 1'b0;
      dado_escrita <= '0;
      parado       <= 1'b0;
      ilegal       <= 1'b0;
    end else begin
      unique case (estado)
        INICIO: begin
          instr_req <= 1'b1;
          estado    <= BUSCA;
        end
        BUSCA: begin
          if (instr_ack) begin
            ir        <= instrucao;
            instr_req <= 1'b0;
            end_a     <= rs_in;
            end_b     <= rt_in;
            habilita  <= 1'b0;
            estado    <= DECODIFICA;
          end
        end
        DECODIFICA: begin
          unique case (classe)
            C_NOP: begin
              pc        <= pc_inc;
              instr_req <= 1'b1;
              estado    <= BUSCA;
            end
            C_ILEGAL: begin
              ilegal    <= 1'b1;
              pc        <= pc_inc;
              instr_req <= 1'b1;
              estado    <= BUSCA;
            end
            C_HALT: begin
              parado <= 1'b1;
              estado <= PARADO;
            end
            C_EXEC: begin
              estado <= EXECUTA;
            end
            default: estado <= EXECUTA;
          endcase
        end
        EXECUTA: begin
          dado_escrita <= resultado;
          end_a        <= rd;
          habilita     <= 1'b1;
          estado       <= ESCRITA;
        end
        ESCRITA: begin
          habilita  <= 1'b0;
          pc        <= pc_inc;
          instr_req <= 1'b1;
          estado    <= BUSCA;
        end
        PARADO: begin
          estado <= PARADO;
        end
        default: estado <= INICIO;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_execucao.sv
// Bench for unidade_execucao: bank model, instruction driver and
// an instruction-level reference model of the Lapido ISA.
module tb_unidade_execucao;

  localparam int W   = 32;
  localparam int AW  = 4;
  localparam int PCW = 6;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           instr_ack = 1'b0;
  logic [31:0]    instrucao = '0;
  logic [W-1:0]   dado_a = '0;
  logic [W-1:0]   dado_b = '0;
  logic           instr_req;
  logic [PCW-1:0] pc;
  logic [AW-1:0]  end_a;
  logic [AW-1:0]  end_b;
  logic           habilita;
  logic [W-1:0]   dado_escrita;
  logic           parado;
  logic           ilegal;

  logic [W-1:0] bank [16];
  logic [W-1:0] ref_regs [16];
  logic         bank_clear = 1'b1;
  int           ref_pc;
  bit           ref_ilegal;
  int           n_cmp = 0;
  int           n_fail = 0;

  unidade_execucao #(
    .bits_palavra (W),
    .end_registros(AW),
    .largura_pc   (PCW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_ack   (instr_ack),
    .instrucao   (instrucao),
    .pc          (pc),
    .end_a       (end_a),
    .end_b       (end_b),
    .habilita    (habilita),
    .dado_escrita(dado_escrita),
    .dado_a      (dado_a),
    .dado_b      (dado_b),
    .parado      (parado),
    .ilegal      (ilegal)
  );

  always #5 clock = ~clock;

  // Register bank: writes and reads on the falling edge.
  always @(negedge clock) begin
    if (bank_clear) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else if (habilita) begin
      bank[end_a] <= dado_escrita;
    end
    dado_a <= bank[end_a];
    dado_b <= bank[end_b];
  end

  function automatic logic [31:0] enc(input logic [5:0] op,
                                      input logic [3:0] rd,
                                      input logic [3:0] rs,
                                      input logic [3:0] rt,
                                      input logic [13:0] im);
    return {op, rd, rs, rt, im};
  endfunction

  task automatic model_reset();
    ref_pc     = 0;
    ref_ilegal = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] ins,
                            output int cyc, output bit wr);
    logic [5:0]          op;
    int                  rd, rs, rt;
    logic signed [31:0]  im;
    op = ins[31:26];
    rd = int'(ins[25:22]);
    rs = int'(ins[21:18]);
    rt = int'(ins[17:14]);
    im = $signed(ins[13:0]);
    cyc = 2;
    wr  = 1'b0;
    if (op >= 6'h01 && op <= 6'h06) begin
      cyc = 4;
      wr  = 1'b1;
      case (op)
        6'h01: ref_regs[rd] = ref_regs[rs] + ref_regs[rt];
        6'h02: ref_regs[rd] = ref_regs[rs] - ref_regs[rt];
        6'h03: ref_regs[rd] = ref_regs[rs] & ref_regs[rt];
        6'h04: ref_regs[rd] = ref_regs[rs] | ref_regs[rt];
        6'h05: ref_regs[rd] = ref_regs[rs] + im;
        default: ref_regs[rd] = im;
      endcase
    end else if (op != 6'h00 && op != 6'h3F) begin
      ref_ilegal = 1'b1;
    end
    if (op != 6'h3F) ref_pc = (ref_pc + 1) % (1 << PCW);
  endtask

  // Drives one instruction; returns cycles from fetch start to the
  // next request (or halt), -1 when a bound expires.
  task automatic do_instr(input logic [31:0] ins, input int delay,
                          input bit noise, output int cyc,
                          output bit wr, output bit hs_ok);
    logic [PCW-1:0] p0;
    cyc = 0;
    wr = 1'b0;
    hs_ok = 1'b1;
    for (int k = 0; k < 20 && !instr_req; k++) begin
      @(posedge clock); #1;
    end
    if (!instr_req) begin
      cyc = -1;
      return;
    end
    p0 = pc;
    for (int d = 0; d < delay; d++) begin
      instr_ack = 1'b0;
      instrucao = $urandom;
      @(posedge clock); #1;
      cyc++;
      if (!instr_req || pc !== p0) hs_ok = 1'b0;
    end
    instrucao = ins;
    instr_ack = 1'b1;
    @(posedge clock); #1;
    cyc++;
    instr_ack = 1'b0;
    if (instr_req) hs_ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (instr_req || parado) break;
      if (noise) begin
        instr_ack = 1'b1;
        instrucao = $urandom;
      end
      @(posedge clock); #1;
      cyc++;
      if (habilita) wr = 1'b1;
    end
    instr_ack = 1'b0;
    if (!(instr_req || parado)) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({instr_req, habilita, end_a, end_b, dado_escrita,
         pc, parado, ilegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b hab=%b a=%h b=%h e=%h pc=%h p=%b il=%b want all 0",
               instr_req, habilita, end_a, end_b, dado_escrita,
               pc, parado, ilegal);
    end
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1 bank_clear = 1'b0;
    n_cmp++;
    if (instr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_before_edge: got %b want 0", instr_req);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (instr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_after_release: got %b want 1", instr_req);
    end
  endtask

  task automatic test_li_add();
    logic [31:0] prog [3];
    int cyc, ecyc;
    bit wr, ewr, hs;
    prog[0] = enc(6'h06, 4'd1, 4'd0, 4'd0, 14'd5);
    prog[1] = enc(6'h06, 4'd2, 4'd0, 4'd0, 14'd7);
    prog[2] = enc(6'h01, 4'd3, 4'd1, 4'd2, 14'd0);
    for (int i = 0; i < 3; i++) begin
      do_instr(prog[i], 0, 1'b0, cyc, wr, hs);
      model_step(prog[i], ecyc, ewr);
      n_cmp++;
      if (cyc != ecyc || wr != ewr) begin
        n_fail++;
        $display("FAIL li_add_latency[%0d]: cyc=%0d wr=%b want cyc=%0d wr=%b",
                 i, cyc, wr, ecyc, ewr);
      end
    end
    n_cmp++;
    if (bank[3] !== 32'd12) begin
      n_fail++;
      $display("FAIL li_add_r3: got %h want 0000000c", bank[3]);
    end
    n_cmp++;
    if (pc !== PCW'(3)) begin
      n_fail++;
      $display("FAIL li_add_pc: got %0d want 3", pc);
    end
  endtask

  task automatic test_sign_wrap();
    logic [31:0] prog [3];
    logic [31:0] want [3];
    int cyc, ecyc;
    bit wr, ewr, hs;
    prog[0] = enc(6'h06, 4'd1, 4'd0, 4'd0, 14'h3FFF);
    prog[1] = enc(6'h05, 4'd2, 4'd1, 4'd0, 14'd1);
    prog[2] = enc(6'h02, 4'd3, 4'd2, 4'd1, 14'd0);
    want[0] = 32'hFFFF_FFFF;
    want[1] = 32'h0000_0000;
    want[2] = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      do_instr(prog[i], 0, 1'b0, cyc, wr, hs);
      model_step(prog[i], ecyc, ewr);
      n_cmp++;
      if (bank[i+1] !== want[i] || cyc != 4) begin
        n_fail++;
        $display("FAIL sign_wrap[%0d]: r%0d=%h cyc=%0d want %h cyc=4",
                 i, i + 1, bank[i+1], cyc, want[i]);
      end
    end
  endtask

  task automatic test_illegal_nop();
    logic [31:0] ins;
    int cyc, ecyc;
    bit wr, ewr, hs;
    ins = enc(6'h10, 4'd5, 4'd1, 4'd2, 14'd9);
    do_instr(ins, 0, 1'b0, cyc, wr, hs);
    model_step(ins, ecyc, ewr);
    n_cmp++;
    if (ilegal !== 1'b1 || wr || cyc != 2 || pc !== PCW'(ref_pc)) begin
      n_fail++;
      $display("FAIL illegal_op: il=%b wr=%b cyc=%0d pc=%0d want il=1 wr=0 cyc=2 pc=%0d",
               ilegal, wr, cyc, pc, ref_pc);
    end
    ins = enc(6'h00, 4'd5, 4'd1, 4'd2, 14'd9);
    do_instr(ins, 0, 1'b0, cyc, wr, hs);
    model_step(ins, ecyc, ewr);
    n_cmp++;
    if (ilegal !== 1'b1 || wr || cyc != 2 || pc !== PCW'(ref_pc)) begin
      n_fail++;
      $display("FAIL nop_after_illegal: il=%b wr=%b cyc=%0d pc=%0d want il=1 wr=0 cyc=2 pc=%0d",
               ilegal, wr, cyc, pc, ref_pc);
    end
  endtask

  task automatic test_ack_delay();
    logic [31:0] ins;
    int cyc, ecyc;
    bit wr, ewr, hs;
    ins = enc(6'h06, 4'd5, 4'd0, 4'd0, 14'h0123);
    do_instr(ins, 3, 1'b0, cyc, wr, hs);
    model_step(ins, ecyc, ewr);
    n_cmp++;
    if (!hs || cyc != ecyc + 3 || bank[5] !== 32'h123) begin
      n_fail++;
      $display("FAIL ack_delay: hs=%b cyc=%0d r5=%h want hs=1 cyc=%0d r5=00000123",
               hs, cyc, bank[5], ecyc + 3);
    end
    ins = enc(6'h04, 4'd6, 4'd5, 4'd3, 14'd0);
    do_instr(ins, 2, 1'b1, cyc, wr, hs);
    model_step(ins, ecyc, ewr);
    n_cmp++;
    if (!hs || cyc != ecyc + 2 || bank[6] !== ref_regs[6]) begin
      n_fail++;
      $display("FAIL ack_delay_noise: hs=%b cyc=%0d r6=%h want hs=1 cyc=%0d r6=%h",
               hs, cyc, bank[6], ecyc + 2, ref_regs[6]);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [5:0]  op;
    int cyc, ecyc, dl, r;
    bit wr, ewr, hs, nz, same;
    for (int n = 0; n < 90; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) op = 6'h00;
      else if (r <= 6) op = 6'(r);
      else if (r == 7) op = 6'h05;
      else if (r == 8) op = 6'($urandom_range(7, 62));
      else op = 6'($urandom_range(1, 6));
      ins = {op, 26'($urandom)};
      dl = int'($urandom_range(0, 2));
      nz = 1'($urandom);
      do_instr(ins, dl, nz, cyc, wr, hs);
      model_step(ins, ecyc, ewr);
      n_cmp++;
      if (!hs || cyc != ecyc + dl || wr != ewr) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: hs=%b cyc=%0d wr=%b want cyc=%0d wr=%b",
                 n, hs, cyc, wr, ecyc + dl, ewr);
      end
      n_cmp++;
      if (pc !== PCW'(ref_pc) || ilegal !== ref_ilegal) begin
        n_fail++;
        $display("FAIL rand_pc[%0d]: pc=%0d il=%b want pc=%0d il=%b",
                 n, pc, ilegal, ref_pc, ref_ilegal);
      end
      same = 1'b1;
      for (int i = 0; i < 16; i++)
        if (bank[i] !== ref_regs[i]) same = 1'b0;
      n_cmp++;
      if (!same) begin
        n_fail++;
        $display("FAIL rand_regs[%0d]: ins=%h r%0d=%h want %h", n, ins,
                 ins[25:22], bank[ins[25:22]], ref_regs[ins[25:22]]);
      end
    end
  endtask

  task automatic test_reset_escrita();
    bit seen;
    for (int k = 0; k < 20 && !instr_req; k++) begin
      @(posedge clock); #1;
    end
    instrucao = enc(6'h01, 4'd6, 4'd1, 4'd2, 14'd0);
    instr_ack = 1'b1;
    @(posedge clock); #1;
    instr_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      if (habilita) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL escrita_reached: habilita never rose, want 1");
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({instr_req, habilita, end_a, end_b, dado_escrita,
         pc, parado, ilegal} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: hab=%b req=%b pc=%0d e=%h il=%b want all 0",
               habilita, instr_req, pc, dado_escrita, ilegal);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (instr_req !== 1'b1 || bank[6] !== ref_regs[6]) begin
      n_fail++;
      $display("FAIL reset_recover: req=%b r6=%h want req=1 r6=%h",
               instr_req, bank[6], ref_regs[6]);
    end
  endtask

  task automatic test_halt();
    logic [31:0] ins;
    int cyc, ecyc;
    bit wr, ewr, hs, bad;
    for (int i = 0; i < 4; i++) begin
      ins = enc(6'h06, 4'(7 + i), 4'd0, 4'd0, 14'($urandom));
      do_instr(ins, 0, 1'b0, cyc, wr, hs);
      model_step(ins, ecyc, ewr);
    end
    ins = enc(6'h3F, 4'd0, 4'd0, 4'd0, 14'd0);
    do_instr(ins, 0, 1'b0, cyc, wr, hs);
    model_step(ins, ecyc, ewr);
    n_cmp++;
    if (parado !== 1'b1 || cyc != 2 || pc !== PCW'(4) || instr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL halt: p=%b cyc=%0d pc=%0d req=%b want p=1 cyc=2 pc=4 req=0",
               parado, cyc, pc, instr_req);
    end
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      instr_ack = 1'b1;
      instrucao = $urandom;
      @(posedge clock); #1;
      if (!parado || instr_req || habilita || pc !== PCW'(4)) bad = 1'b1;
    end
    instr_ack = 1'b0;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL halt_hold: p=%b req=%b hab=%b pc=%0d want p=1 req=0 hab=0 pc=4",
               parado, instr_req, habilita, pc);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(posedge clock); #1;
    n_cmp++;
    if (parado !== 1'b0 || instr_req !== 1'b1 || pc !== '0) begin
      n_fail++;
      $display("FAIL halt_exit: p=%b req=%b pc=%0d want p=0 req=1 pc=0",
               parado, instr_req, pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_li_add();
    test_sign_wrap();
    test_illegal_nop();
    test_ack_delay();
    test_random();
    test_reset_escrita();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
